// File: rtl/height_digit_renderer.sv
// VGA raster stage: 640x480 timing, glyph ROM addressing for a 3-digit BCD
// height field, and registered pixel/sync outputs.
module height_digit_renderer #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned X0       = 292,
   parameter int unsigned Y0       = 232,
   parameter int unsigned LZ_BLANK = 1,
   parameter logic [5:0]  BG       = 6'b111111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] digits_in,
   output logic [4:0]  glyph_col,
   output logic [4:0]  glyph_row,
   output logic [3:0]  glyph_sel,
   input  logic [5:0]  glyph_data,
   output logic [5:0]  rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        active
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FIELD_W = 24;
   localparam int unsigned FIELD_H = 16;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] FX0      = 10'(X0);
   localparam logic [9:0] FX1      = 10'(X0 + FIELD_W);
   localparam logic [9:0] FY0      = 10'(Y0);
   localparam logic [9:0] FY1      = 10'(Y0 + FIELD_H);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic [11:0]      digits_q, digits_d;
   logic [5:0]       rgb_q, rgb_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             active_q, active_d;

   logic             tick;
   logic             in_field;
   logic [4:0]       dx;
   logic [3:0]       dy;
   logic [3:0]       digit_val;
   logic             lead_zero;
   logic             blank;
   logic             show;
   logic             visible;

   assign tick = (div_cnt_q == DIV_LAST);

   // Field decode; offsets are only formed inside the field
   always_comb begin
      in_field  = (h_cnt_q >= FX0) && (h_cnt_q < FX1) &&
                  (v_cnt_q >= FY0) && (v_cnt_q < FY1);
      dx        = '0;
      dy        = '0;
      if (in_field) begin
         dx = 5'(h_cnt_q - FX0);
         dy = 4'(v_cnt_q - FY0);
      end
      digit_val = digits_q[3:0];
      lead_zero = 1'b0;
      case (dx[4:3])
         2'd0: begin
            digit_val = digits_q[11:8];
            lead_zero = (digits_q[11:8] == 4'd0);
         end
         2'd1: begin
            digit_val = digits_q[7:4];
            lead_zero = (digits_q[11:4] == 8'd0);
         end
         default: begin
            digit_val = digits_q[3:0];
            lead_zero = 1'b0;
         end
      endcase
      blank     = (digit_val > 4'd9) || ((LZ_BLANK != 0) && lead_zero);
      show      = in_field && !blank;
      visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      glyph_sel = show ? digit_val : 4'd0;
      glyph_col = {2'b00, dx[2:0]};
      glyph_row = {1'b0, dy};
   end

   // Next-state: counters, frame latch and pixel pipeline advance on ticks only
   always_comb begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      digits_d  = digits_q;
      rgb_d     = rgb_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      active_d  = active_q;
      if (tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d  = '0;
               digits_d = digits_in;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
         hsync_d  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
         vsync_d  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
         active_d = visible;
         if (!visible) begin
            rgb_d = 6'd0;
         end else if (show) begin
            rgb_d = glyph_data;
         end else begin
            rgb_d = BG;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         digits_q  <= 12'h000;
         rgb_q     <= 6'd0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         active_q  <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         digits_q  <= digits_d;
         rgb_q     <= rgb_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         active_q  <= active_d;
      end
   end

   assign rgb    = rgb_q;
   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign active = active_q;

endmodule

// File: tb/tb_height_digit_renderer.sv
// Scoreboard bench for height_digit_renderer on a reduced raster
// (80x48 ticks per frame, digit field at x=20..43, y=10..25).
module tb_height_digit_renderer;

   localparam int CDIV = 2;
   localparam int HT   = 80;
   localparam int VT   = 48;
   localparam int FT   = HT * VT;
   localparam logic [5:0] BGC = 6'b111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] digits_in;
   logic [4:0]  glyph_col;
   logic [4:0]  glyph_row;
   logic [3:0]  glyph_sel;
   logic [5:0]  glyph_data;
   logic [5:0]  rgb;
   logic        hsync;
   logic        vsync;
   logic        active;

   always #5 clk = ~clk;

   height_digit_renderer #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .CLK_DIV(CDIV), .X0(20), .Y0(10), .LZ_BLANK(1), .BG(BGC)
   ) dut (
      .clk(clk), .reset(reset), .digits_in(digits_in),
      .glyph_col(glyph_col), .glyph_row(glyph_row), .glyph_sel(glyph_sel),
      .glyph_data(glyph_data), .rgb(rgb), .hsync(hsync), .vsync(vsync),
      .active(active)
   );

   // Glyph ROM model; glyph 0 is dark at (row 1, col 2)
   function automatic logic [5:0] rom_f(logic [3:0] s, logic [4:0] r, logic [4:0] c);
      logic [3:0] s1;
      s1 = s + 4'd1;
      if (s == 4'd0 && r == 5'd1 && c == 5'd2) return 6'd0;
      return {s1[2:0], r[1:0] ^ c[1:0], c[0]};
   endfunction

   assign glyph_data = rom_f(glyph_sel, glyph_row, glyph_col);

   typedef struct {
      int         t;
      int         x;
      int         y;
      bit         is_pix;
      logic [5:0] rgb;
      logic       act;
      logic       hs;
      logic       vs;
      logic [3:0] sel;
      logic [4:0] row;
      logic [4:0] col;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   function automatic int at(int f, int x, int y);
      return f * FT + y * HT + x;
   endfunction

   task automatic push(exp_t e);
      int i;
      i = 0;
      while (i < sb.size() && sb[i].t <= e.t) i++;
      sb.insert(i, e);
   endtask

   task automatic exp_addr(int f, int x, int y, logic [3:0] s, logic [4:0] r, logic [4:0] c);
      exp_t e;
      e = '{default: 0};
      e.t = at(f, x, y); e.x = x; e.y = y; e.is_pix = 1'b0;
      e.sel = s; e.row = r; e.col = c;
      push(e);
   endtask

   task automatic exp_pix(int f, int x, int y, logic [5:0] c, logic a, logic h, logic v);
      exp_t e;
      e = '{default: 0};
      e.t = at(f, x, y) + 1; e.x = x; e.y = y; e.is_pix = 1'b1;
      e.rgb = c; e.act = a; e.hs = h; e.vs = v;
      push(e);
   endtask

   // Address and rendered colour of one field pixel
   task automatic exp_glyph(int f, int x, int y, logic [3:0] s, logic [4:0] r, logic [4:0] c);
      exp_addr(f, x, y, s, r, c);
      exp_pix(f, x, y, rom_f(s, r, c), 1'b1, 1'b1, 1'b1);
   endtask

   task automatic exp_bg(int f, int x, int y);
      exp_pix(f, x, y, BGC, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic check_reset_outputs(int tag);
      checks++;
      if ({rgb, active, hsync, vsync, glyph_sel, glyph_row, glyph_col} !==
          {6'd0, 1'b0, 1'b1, 1'b1, 4'd0, 5'd0, 5'd0}) begin
         errors++;
         $display("FAIL reset%0d: rgb=%b act=%b hs=%b vs=%b sel=%0d row=%0d col=%0d, expected rgb=000000 act=0 hs=1 vs=1 sel=0 row=0 col=0",
                  tag, rgb, active, hsync, vsync, glyph_sel, glyph_row, glyph_col);
      end
   endtask

   task automatic wait_tick(int t);
      while (cyc / CDIV < t) @(negedge clk);
   endtask

   // Monitor: compare every expectation due at the current tick
   always @(negedge clk) begin
      if (!reset) begin
         while (sb.size() > 0 && sb[0].t <= cyc / CDIV) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.t != cyc / CDIV) begin
               errors++;
               $display("FAIL missed (%0d,%0d): due tick %0d, now tick %0d",
                        mon_e.x, mon_e.y, mon_e.t, cyc / CDIV);
            end else if (mon_e.is_pix) begin
               if ({rgb, active, hsync, vsync} !== {mon_e.rgb, mon_e.act, mon_e.hs, mon_e.vs}) begin
                  errors++;
                  $display("FAIL pix f%0d (%0d,%0d): rgb=%b act=%b hs=%b vs=%b, expected rgb=%b act=%b hs=%b vs=%b",
                           mon_e.t / FT, mon_e.x, mon_e.y, rgb, active, hsync, vsync,
                           mon_e.rgb, mon_e.act, mon_e.hs, mon_e.vs);
               end
            end else begin
               if ({glyph_sel, glyph_row, glyph_col} !== {mon_e.sel, mon_e.row, mon_e.col}) begin
                  errors++;
                  $display("FAIL addr f%0d (%0d,%0d): sel=%0d row=%0d col=%0d, expected sel=%0d row=%0d col=%0d",
                           mon_e.t / FT, mon_e.x, mon_e.y, glyph_sel, glyph_row, glyph_col,
                           mon_e.sel, mon_e.row, mon_e.col);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      digits_in = 12'h120;
      #1;
      check_reset_outputs(0);

      // Frame 0: digits_q still 000, only digit 2 shows "0"; sync/active timing
      exp_pix(0, 0, 0, BGC, 1'b1, 1'b1, 1'b1);
      exp_pix(0, 63, 0, BGC, 1'b1, 1'b1, 1'b1);
      exp_pix(0, 64, 0, 6'd0, 1'b0, 1'b1, 1'b1);
      exp_pix(0, 67, 0, 6'd0, 1'b0, 1'b1, 1'b1);
      exp_pix(0, 68, 0, 6'd0, 1'b0, 1'b0, 1'b1);
      exp_pix(0, 75, 0, 6'd0, 1'b0, 1'b0, 1'b1);
      exp_pix(0, 76, 0, 6'd0, 1'b0, 1'b1, 1'b1);
      exp_pix(0, 68, 1, 6'd0, 1'b0, 1'b0, 1'b1);
      exp_addr(0, 20, 10, 4'd0, 5'd0, 5'd0);
      exp_bg(0, 20, 10);
      exp_addr(0, 28, 10, 4'd0, 5'd0, 5'd0);
      exp_bg(0, 28, 10);
      exp_glyph(0, 36, 10, 4'd0, 5'd0, 5'd0);
      exp_glyph(0, 39, 13, 4'd0, 5'd3, 5'd3);
      exp_pix(0, 0, 39, BGC, 1'b1, 1'b1, 1'b1);
      exp_pix(0, 0, 40, 6'd0, 1'b0, 1'b1, 1'b1);
      exp_pix(0, 0, 41, 6'd0, 1'b0, 1'b1, 1'b1);
      exp_pix(0, 0, 42, 6'd0, 1'b0, 1'b1, 1'b0);
      exp_pix(0, 79, 43, 6'd0, 1'b0, 1'b1, 1'b0);
      exp_pix(0, 0, 44, 6'd0, 1'b0, 1'b1, 1'b1);
      exp_pix(0, 79, 47, 6'd0, 1'b0, 1'b1, 1'b1);

      // Frame 1: "120"
      exp_addr(1, 19, 10, 4'd0, 5'd0, 5'd0);
      exp_bg(1, 19, 10);
      exp_glyph(1, 20, 10, 4'd1, 5'd0, 5'd0);
      exp_glyph(1, 38, 11, 4'd0, 5'd1, 5'd2);
      exp_pix(1, 38, 11, 6'd0, 1'b1, 1'b1, 1'b1);
      exp_glyph(1, 28, 15, 4'd2, 5'd5, 5'd0);
      exp_glyph(1, 43, 25, 4'd0, 5'd15, 5'd7);
      exp_addr(1, 44, 10, 4'd0, 5'd0, 5'd0);
      exp_bg(1, 44, 10);
      exp_addr(1, 20, 9, 4'd0, 5'd0, 5'd0);
      exp_bg(1, 20, 9);
      exp_addr(1, 20, 26, 4'd0, 5'd0, 5'd0);
      exp_bg(1, 20, 26);
      exp_pix(1, 0, 42, 6'd0, 1'b0, 1'b1, 1'b0);

      // Frame 2: "007" with leading zeros blanked
      exp_addr(2, 20, 10, 4'd0, 5'd0, 5'd0);
      exp_bg(2, 20, 10);
      exp_addr(2, 27, 25, 4'd0, 5'd15, 5'd7);
      exp_bg(2, 27, 25);
      exp_bg(2, 28, 10);
      exp_bg(2, 35, 17);
      exp_glyph(2, 36, 10, 4'd7, 5'd0, 5'd0);
      exp_glyph(2, 40, 12, 4'd7, 5'd2, 5'd4);

      // Frame 3: "1A3", middle digit invalid
      exp_glyph(3, 20, 10, 4'd1, 5'd0, 5'd0);
      exp_bg(3, 28, 10);
      exp_bg(3, 35, 11);
      exp_glyph(3, 36, 10, 4'd3, 5'd0, 5'd0);

      // Frame 4: "111" held although input changes mid-frame; frame 5: "222"
      exp_glyph(4, 30, 12, 4'd1, 5'd2, 5'd2);
      exp_glyph(4, 30, 22, 4'd1, 5'd12, 5'd2);
      exp_glyph(4, 20, 25, 4'd1, 5'd15, 5'd0);
      exp_glyph(5, 20, 10, 4'd2, 5'd0, 5'd0);
      exp_glyph(5, 30, 12, 4'd2, 5'd2, 5'd2);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      wait_tick(at(1, 0, 30));
      digits_in = 12'h007;
      wait_tick(at(2, 0, 30));
      digits_in = 12'h1A3;
      wait_tick(at(3, 0, 30));
      digits_in = 12'h111;
      wait_tick(at(4, 0, 20));
      digits_in = 12'h222;

      // Asynchronous reset in the visible area, away from a clock edge
      wait_tick(at(5, 10, 30));
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs(1);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending: %0d expectations left before reset, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
      check_reset_outputs(2);

      // After reset digits_q is 000 again even though digits_in is 222
      exp_pix(0, 0, 0, BGC, 1'b1, 1'b1, 1'b1);
      exp_addr(0, 20, 10, 4'd0, 5'd0, 5'd0);
      exp_bg(0, 20, 10);
      exp_bg(0, 28, 10);
      exp_glyph(0, 36, 10, 4'd0, 5'd0, 5'd0);
      exp_glyph(0, 38, 11, 4'd0, 5'd1, 5'd2);
      reset = 1'b0;

      while (sb.size() > 0) @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
